// File: rtl/dsi_pkg.sv
// ---------------------------------------------------------------------------
// dsi_pkg
// Shared definitions for the DSI lane group controller.
//   dsi_state_e      : sequencer state encoding (HS_SOT exists only when
//                      DSI_LANE_GROUP_SOT_EN is defined)
//   DSI_SOT_BYTE     : start-of-transmission sync byte
//   DSI_HS_ZERO_BYTE : byte driven during HS-ZERO
//   DSI_LP11/01/00   : {lp_p, lp_n} line codes
//   dsi_trail_byte() : HS-TRAIL byte, the inverse of the last bit sent
// Build macro: DSI_LANE_GROUP_SOT_EN
// ---------------------------------------------------------------------------
package dsi_pkg;

  typedef enum logic [3:0] {
    ST_DISABLED,
    ST_IDLE,
    ST_HS_RQST,
    ST_HS_PREP,
    ST_HS_ZERO,
`ifdef DSI_LANE_GROUP_SOT_EN
    ST_HS_SOT,
`endif
    ST_HS_DATA,
    ST_HS_TRAIL,
    ST_HS_EXIT
  } dsi_state_e;

  localparam logic [7:0] DSI_SOT_BYTE     = 8'hB8;
  localparam logic [7:0] DSI_HS_ZERO_BYTE = 8'h00;

  localparam logic [1:0] DSI_LP11 = 2'b11;
  localparam logic [1:0] DSI_LP01 = 2'b01;
  localparam logic [1:0] DSI_LP00 = 2'b00;

  // The serializer sends LSB first, so bit 7 is the final bit on the wire;
  // the trail holds the opposite level of that bit.
  function automatic logic [7:0] dsi_trail_byte(input logic [7:0] last_byte);
    return last_byte[7] ? 8'h00 : 8'hFF;
  endfunction

endpackage

// File: rtl/dsi_lane_group_ctrl_if.sv
// ---------------------------------------------------------------------------
// dsi_lane_group_ctrl_if
// Byte-stream handshake between the packet assembler and the lane group.
//   s_data  : one byte per lane, byte k -> lane k
//   s_valid : beat valid
//   s_last  : final beat of the burst
//   s_ready : beat accepted when s_valid & s_ready
// Modports: master (packet assembler), slave (lane group controller).
// ---------------------------------------------------------------------------
interface dsi_lane_group_ctrl_if #(
  parameter int N_LANES = 4
);

  logic [8*N_LANES-1:0] s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/dsi_phase_timer.sv
// ---------------------------------------------------------------------------
// dsi_phase_timer
// Down-counter that times one sequencer phase.
//   clk_sys, rst_n : byte clock, async active-low reset
//   load           : reload on entry to a timed phase
//   load_val       : phase length in cycles (0 behaves as 1)
//   timeout        : high during the final cycle of the phase
// ---------------------------------------------------------------------------
module dsi_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Loading len-1 makes the phase last len cycles, with timeout on the last
  // one; a zero length loads 0 and so lasts a single cycle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? '0 : load_val - ONE;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign timeout = (cnt == '0);

endmodule

// File: rtl/dsi_lane_group_ctrl.sv
// ---------------------------------------------------------------------------
// dsi_lane_group_ctrl
// Drives N_LANES D-PHY data lanes in lockstep through
// LP-11 -> LP-01 -> LP-00 -> HS-ZERO -> (SoT) -> HS data -> HS-TRAIL -> LP-11.
// Ports:
//   clk_sys, rst_n      : byte clock, async active-low reset
//   lines_enable        : lanes enabled (leaves/enters DISABLED from IDLE)
//   start_rqst          : level request for an HS burst, sampled in IDLE
//   cfg_t_lpx/prep/zero/trail/exit : phase lengths in clk_sys cycles
//   s_bus               : byte stream from the packet assembler (slave)
//   hs_data, hs_oe      : bytes to the serializers and HS driver enable
//   lp_p, lp_n, lp_oe   : shared LP line levels and LP driver enable
//   busy                : burst in progress (not DISABLED/IDLE)
//   underrun            : one-cycle pulse when the stream starves mid-burst
// Build macro: DSI_LANE_GROUP_SOT_EN adds a one-cycle HS_SOT (0xB8) phase.
// ---------------------------------------------------------------------------
module dsi_lane_group_ctrl
  import dsi_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 lines_enable,
  input  logic                 start_rqst,
  input  logic [CNT_W-1:0]     cfg_t_lpx,
  input  logic [CNT_W-1:0]     cfg_t_prep,
  input  logic [CNT_W-1:0]     cfg_t_zero,
  input  logic [CNT_W-1:0]     cfg_t_trail,
  input  logic [CNT_W-1:0]     cfg_t_exit,
  dsi_lane_group_ctrl_if.slave s_bus,
  output logic [8*N_LANES-1:0] hs_data,
  output logic                 hs_oe,
  output logic                 lp_p,
  output logic                 lp_n,
  output logic                 lp_oe,
  output logic                 busy,
  output logic                 underrun
);

  dsi_state_e           state;

  // cfg_t_lpx is consumed on the same edge it would be latched, so only
  // the later phases need shadow copies.
  logic [CNT_W-1:0]     sh_prep;
  logic [CNT_W-1:0]     sh_zero;
  logic [CNT_W-1:0]     sh_trail;
  logic [CNT_W-1:0]     sh_exit;

  logic [8*N_LANES-1:0] last_tx;
  logic [8*N_LANES-1:0] trail_word;

  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_done;

  dsi_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .timeout (tmr_done)
  );

  // Reload the timer on the edge that enters each timed phase, using the
  // length of the phase being entered.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (lines_enable && start_rqst) begin
          tmr_load = 1'b1;
          tmr_val  = cfg_t_lpx;
        end
      end
      ST_HS_RQST: begin
        tmr_load = tmr_done;
        tmr_val  = sh_prep;
      end
      ST_HS_PREP: begin
        tmr_load = tmr_done;
        tmr_val  = sh_zero;
      end
      ST_HS_DATA: begin
        tmr_load = !s_bus.s_valid || s_bus.s_last;
        tmr_val  = sh_trail;
      end
      ST_HS_TRAIL: begin
        tmr_load = tmr_done;
        tmr_val  = sh_exit;
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  // Per-lane trail byte derived from the last byte each lane transmitted.
  always_comb begin
    trail_word = '0;
    for (int k = 0; k < N_LANES; k++) begin
      trail_word[8*k +: 8] = dsi_trail_byte(last_tx[8*k +: 8]);
    end
  end

  // Sequencer. hs_data is one cycle behind the state: it shows what the
  // previous state produced. On starvation hs_data holds its last byte.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_DISABLED;
      sh_prep  <= '0;
      sh_zero  <= '0;
      sh_trail <= '0;
      sh_exit  <= '0;
      last_tx  <= '0;
      hs_data  <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;

      case (state)
        ST_DISABLED: begin
          if (lines_enable) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!lines_enable) begin
            state <= ST_DISABLED;
          end else if (start_rqst) begin
            state    <= ST_HS_RQST;
            sh_prep  <= cfg_t_prep;
            sh_zero  <= cfg_t_zero;
            sh_trail <= cfg_t_trail;
            sh_exit  <= cfg_t_exit;
            last_tx  <= '0;
          end
        end
        ST_HS_RQST: begin
          if (tmr_done) state <= ST_HS_PREP;
        end
        ST_HS_PREP: begin
          if (tmr_done) state <= ST_HS_ZERO;
        end
        ST_HS_ZERO: begin
`ifdef DSI_LANE_GROUP_SOT_EN
          if (tmr_done) state <= ST_HS_SOT;
`else
          if (tmr_done) state <= ST_HS_DATA;
`endif
        end
`ifdef DSI_LANE_GROUP_SOT_EN
        ST_HS_SOT: begin
          state <= ST_HS_DATA;
        end
`endif
        ST_HS_DATA: begin
          if (!s_bus.s_valid) begin
            underrun <= 1'b1;
            state    <= ST_HS_TRAIL;
          end else begin
            last_tx <= s_bus.s_data;
            if (s_bus.s_last) state <= ST_HS_TRAIL;
          end
        end
        ST_HS_TRAIL: begin
          if (tmr_done) state <= ST_HS_EXIT;
        end
        ST_HS_EXIT: begin
          if (tmr_done) state <= ST_IDLE;
        end
        default: begin
          state <= ST_DISABLED;
        end
      endcase

      case (state)
        ST_HS_DATA: begin
          if (s_bus.s_valid) hs_data <= s_bus.s_data;
        end
        ST_HS_TRAIL: begin
          hs_data <= trail_word;
        end
`ifdef DSI_LANE_GROUP_SOT_EN
        ST_HS_SOT: begin
          hs_data <= {N_LANES{DSI_SOT_BYTE}};
        end
`endif
        default: begin
          hs_data <= {N_LANES{DSI_HS_ZERO_BYTE}};
        end
      endcase
    end
  end

  // Line drivers decoded straight from the state register. In HS states the
  // LP pins are released (lp_oe=0) and parked low.
  always_comb begin
    {lp_p, lp_n} = DSI_LP11;
    lp_oe        = 1'b0;
    hs_oe        = 1'b0;
    case (state)
      ST_IDLE, ST_HS_EXIT: begin
        lp_oe = 1'b1;
      end
      ST_HS_RQST: begin
        {lp_p, lp_n} = DSI_LP01;
        lp_oe        = 1'b1;
      end
      ST_HS_PREP: begin
        {lp_p, lp_n} = DSI_LP00;
        lp_oe        = 1'b1;
      end
      ST_HS_ZERO,
`ifdef DSI_LANE_GROUP_SOT_EN
      ST_HS_SOT,
`endif
      ST_HS_DATA, ST_HS_TRAIL: begin
        {lp_p, lp_n} = DSI_LP00;
        hs_oe        = 1'b1;
      end
      default: begin
        lp_oe = 1'b0;
      end
    endcase
  end

  assign busy         = (state != ST_DISABLED) && (state != ST_IDLE);
  assign s_bus.s_ready = (state == ST_HS_DATA);

endmodule

// File: doc/dsi_lane_group_ctrl.md
Name: dsi_lane_group_ctrl

Overview:
- Multi-lane successor of the single DSI lane LP/HS sequencer. Drives N_LANES data lanes in lockstep through the full D-PHY sequence: LP-11, LP-01, LP-00, HS-ZERO, optional SoT, HS data, HS-TRAIL, LP-11.
- Timing is run-time programmable. Adds HS-ZERO/HS-TRAIL phases, underrun detection and a deterministic exit path.
- Sits between the packet assembler (valid/ready byte stream) and the per-lane serializers/LP buffers.

Parameters:
- N_LANES, 4, number of data lanes (1..4); byte k of s_data goes to lane k.
- CNT_W, 8, width of timing counters and cfg_t_* ports.

Ports:
- clk_sys  in  1  byte clock.
- rst_n  in  1  async active-low reset.
- lines_enable  in  1  enable lanes; DISABLED when low in IDLE.
- start_rqst  in  1  level; begin HS burst when sampled in IDLE.
- cfg_t_lpx, cfg_t_prep, cfg_t_zero, cfg_t_trail, cfg_t_exit  in  CNT_W each  phase durations in clk_sys cycles.
- s_data  in  8*N_LANES  byte per lane.
- s_valid  in  1  data valid.
- s_last  in  1  final beat of burst.
- s_ready  out  1  beat accepted when s_valid&s_ready.
- hs_data  out  8*N_LANES  bytes to serializers (LSB sent first).
- hs_oe  out  1  HS driver enable.
- lp_p, lp_n  out  1 each  LP line levels (shared by all lanes).
- lp_oe  out  1  LP driver enable.
- busy  out  1  high in any state except DISABLED/IDLE.
- underrun  out  1  one-cycle pulse on mid-burst starvation.

Behaviour:
- Reset: all lines async, regardless of prior state. State DISABLED; lp_p=lp_n=1, lp_oe=0, hs_oe=0, hs_data=0, s_ready=0, busy=0, underrun=0.
- FSM states: DISABLED, IDLE, HS_RQST, HS_PREP, HS_ZERO, HS_SOT (macro only), HS_DATA, HS_TRAIL, HS_EXIT.
- Transitions:
  - DISABLED->IDLE when lines_enable=1.
  - IDLE->DISABLED when lines_enable=0 (takes priority over start_rqst).
  - IDLE->HS_RQST when start_rqst=1.
  - HS_RQST->HS_PREP->HS_ZERO->(HS_SOT)->HS_DATA on timeout.
  - HS_DATA->HS_TRAIL on an accepted beat with s_last=1, or when s_valid=0 (underrun).
  - HS_TRAIL->HS_EXIT->IDLE on timeout. HS_EXIT never returns to HS states.
  - lines_enable is ignored outside DISABLED/IDLE. A burst always completes.
- Timed states:
  - All five cfg_t_* values are latched into shadow registers on the IDLE->HS_RQST edge. Changes mid-burst have no effect.
  - Each timed state lasts exactly max(cfg,1) cycles; a value of 0 is treated as 1.
  - One down-counter is reloaded on every state entry.
- Outputs are decoded from the registered state (no added latency):
  - IDLE, HS_EXIT: lp=11, lp_oe=1.
  - HS_RQST: lp=01, lp_oe=1.
  - HS_PREP: lp=00, lp_oe=1.
  - HS_ZERO..HS_TRAIL: lp_oe=0, hs_oe=1.
  - DISABLED: lp_oe=0, hs_oe=0.
- hs_data (registered, one-cycle latency from acceptance):
  - HS_ZERO: all lanes 0x00.
  - HS_DATA: accepted byte per lane. During the underrun cycle it holds the previous byte.
  - HS_TRAIL: per lane, 0xFF if bit7 of that lane's last transmitted byte is 0, else 0x00.
  - Elsewhere: 0x00.
- s_ready=1 only while state==HS_DATA.
- Underrun: s_valid=0 in HS_DATA (including the first HS_DATA cycle) -> underrun pulses 1 cycle, state goes to HS_TRAIL. The trail polarity uses the last transmitted byte, or 0x00 if none was sent (trail=0xFF).
- Simultaneous events: start_rqst and lines_enable=0 in IDLE -> DISABLED. s_last with s_valid=0 is ignored (counts as underrun).

Optional Feature:
- DSI_LANE_GROUP_SOT_EN:
  - Defined: adds HS_SOT for exactly 1 cycle between HS_ZERO and HS_DATA. hs_data=0xB8 on every lane; s_ready=0.
  - Undefined: HS_ZERO goes directly to HS_DATA, and the HS_SOT state encoding is absent.

Decomposition:
- Shared package dsi_pkg holds:
  - the state enum typedef;
  - localparams DSI_SOT_BYTE=8'hB8, DSI_HS_ZERO_BYTE=8'h00, DSI_LP11/LP01/LP00 2-bit codes.
- One natural sub-module, dsi_phase_timer: load/decrement/timeout counter with the max(cfg,1) rule, CNT_W parameterised.

Test Plan:
- Reset/enable: rst_n low mid-HS_DATA -> immediate DISABLED outputs. Release with lines_enable=1 -> IDLE next cycle, lp=11, lp_oe=1.
- Nominal burst, N_LANES=4, cfg = lpx 3 / prep 2 / zero 4 / trail 2 / exit 3, 3 beats, last=0x80 on all lanes:
  - LP01 for 3 cycles, LP00 for 2, 0x00 for 4, then the 3 bytes.
  - Trail 0x00 for 2 cycles, LP11 for 3 cycles, busy low afterwards.
- Zero config: all cfg_t_*=0 -> each timed phase lasts exactly 1 cycle.
- Underrun: drop s_valid after 1 of 4 beats (byte 0x01) -> underrun 1-cycle pulse, trail 0xFF, then exit to IDLE.
- Config shadowing and disable priority:
  - Change cfg_t_zero 4->10 during HS_PREP -> ZERO still lasts 4 cycles.
  - lines_enable=0 together with start_rqst in IDLE -> DISABLED, no LP01.
- SoT macro: with DSI_LANE_GROUP_SOT_EN defined, 1 cycle of 0xB8 between zeros and data with s_ready=0. Without it, 0xB8 never appears.
